// File: rtl/greedy_path_walker.sv
// Greedy Q-table policy walker on a 6x6 grid.
// Emits each visited state, then reports how the walk ended.
module greedy_path_walker #(
  parameter int MAX_STEPS = 36
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  start_state,
  input  logic [5:0]  target_state,
  input  logic [31:0] q_table [37][4],
  output logic        busy,
  output logic        path_valid,
  output logic [5:0]  path_state,
  output logic [5:0]  path_idx,
  output logic        done,
  output logic        success,
  output logic [2:0]  err_code,
  output logic [5:0]  path_len
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_EMIT   = 3'd1;
  localparam logic [2:0] S_EVAL   = 3'd2;
  localparam logic [2:0] S_STEP   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam logic [2:0] E_OK    = 3'd0;
  localparam logic [2:0] E_DEAD  = 3'd1;
  localparam logic [2:0] E_LOOP  = 3'd2;
  localparam logic [2:0] E_LIMIT = 3'd3;
  localparam logic [2:0] E_BAD   = 3'd4;

  localparam logic [5:0] MAX_C = 6'(MAX_STEPS);

  logic [2:0]  state_q, state_d;
  logic [5:0]  cur_q, cur_d;
  logic [5:0]  tgt_q, tgt_d;
  logic [36:0] vis_q, vis_d;
  logic [5:0]  step_q, step_d;
  logic [1:0]  act_q, act_d;
  logic [31:0] best_q, best_d;
  logic [1:0]  bact_q, bact_d;
  logic        bvld_q, bvld_d;
  logic        succ_q, succ_d;
  logic [2:0]  err_q, err_d;
  logic [5:0]  len_q, len_d;

  logic [5:0]  lin;
  logic [5:0]  row;
  logic [5:0]  col;
  logic        legal;
  logic [31:0] q_cur;
  logic        upd;
  logic [5:0]  nxt;
  logic        bad_in;

  // Row/column of the current state for move legality.
  always_comb begin
    lin = cur_q - 6'd1;
    row = lin / 6'd6;
    col = lin % 6'd6;
  end

  // Legality and candidate test for the action under evaluation.
  always_comb begin
    legal = 1'b0;
    case (act_q)
      2'd0:    legal = (row != 6'd0);
      2'd1:    legal = (col != 6'd5);
      2'd2:    legal = (row != 6'd5);
      default: legal = (col != 6'd0);
    endcase
    q_cur = q_table[cur_q][act_q];
    upd = legal && (q_cur != 32'd0) &&
          (!bvld_q || (q_cur > best_q));
  end

  // Neighbour reached by the chosen best action.
  always_comb begin
    nxt = cur_q;
    case (bact_q)
      2'd0:    nxt = cur_q - 6'd6;
      2'd1:    nxt = cur_q + 6'd1;
      2'd2:    nxt = cur_q + 6'd6;
      default: nxt = cur_q - 6'd1;
    endcase
  end

  // Out-of-grid start or target aborts the request.
  always_comb begin
    bad_in = (start_state == 6'd0) || (start_state > 6'd36) ||
             (target_state == 6'd0) || (target_state > 6'd36);
  end

  // Walk control: next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    vis_d   = vis_q;
    step_d  = step_q;
    act_d   = act_q;
    best_d  = best_q;
    bact_d  = bact_q;
    bvld_d  = bvld_q;
    succ_d  = succ_q;
    err_d   = err_q;
    len_d   = len_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (start) begin
          cur_d  = start_state;
          tgt_d  = target_state;
          vis_d  = '0;
          step_d = 6'd0;
          succ_d = 1'b0;
          err_d  = E_OK;
          len_d  = 6'd0;
          if (bad_in) begin
            err_d   = E_BAD;
            state_d = S_FINISH;
          end else begin
            vis_d[start_state] = 1'b1;
            state_d = S_EMIT;
          end
        end
      end
      (state_q == S_EMIT): begin
        if (cur_q == tgt_q) begin
          succ_d  = 1'b1;
          err_d   = E_OK;
          len_d   = step_q;
          state_d = S_FINISH;
        end else if (step_q == MAX_C) begin
          err_d   = E_LIMIT;
          len_d   = step_q;
          state_d = S_FINISH;
        end else begin
          act_d   = 2'd0;
          bvld_d  = 1'b0;
          best_d  = 32'd0;
          bact_d  = 2'd0;
          state_d = S_EVAL;
        end
      end
      (state_q == S_EVAL): begin
        if (upd) begin
          best_d = q_cur;
          bact_d = act_q;
          bvld_d = 1'b1;
        end
        act_d = act_q + 2'd1;
        if (act_q == 2'd3) begin
          state_d = S_STEP;
        end
      end
      (state_q == S_STEP): begin
        if (!bvld_q) begin
          err_d   = E_DEAD;
          len_d   = step_q;
          state_d = S_FINISH;
        end else if (vis_q[nxt]) begin
          err_d   = E_LOOP;
          len_d   = step_q;
          state_d = S_FINISH;
        end else begin
          cur_d      = nxt;
          vis_d[nxt] = 1'b1;
          step_d     = step_q + 6'd1;
          state_d    = S_EMIT;
        end
      end
      (state_q == S_FINISH): begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cur_q   <= 6'd0;
      tgt_q   <= 6'd0;
      vis_q   <= '0;
      step_q  <= 6'd0;
      act_q   <= 2'd0;
      best_q  <= 32'd0;
      bact_q  <= 2'd0;
      bvld_q  <= 1'b0;
      succ_q  <= 1'b0;
      err_q   <= E_OK;
      len_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      vis_q   <= vis_d;
      step_q  <= step_d;
      act_q   <= act_d;
      best_q  <= best_d;
      bact_q  <= bact_d;
      bvld_q  <= bvld_d;
      succ_q  <= succ_d;
      err_q   <= err_d;
      len_q   <= len_d;
    end
  end

  // Outputs decode directly from state and held result registers.
  always_comb begin
    busy       = (state_q != S_IDLE);
    path_valid = (state_q == S_EMIT);
    path_state = cur_q;
    path_idx   = step_q;
    done       = (state_q == S_FINISH);
    success    = succ_q;
    err_code   = err_q;
    path_len   = len_q;
  end

endmodule

// File: tb/tb_greedy_path_walker.sv
// Scoreboard bench for greedy_path_walker.
// Directed walks with hand-computed paths and results.
module tb_greedy_path_walker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  start_state = 6'd0;
  logic [5:0]  target_state = 6'd0;
  logic [31:0] q_table [37][4];
  logic        busy;
  logic        path_valid;
  logic [5:0]  path_state;
  logic [5:0]  path_idx;
  logic        done;
  logic        success;
  logic [2:0]  err_code;
  logic [5:0]  path_len;

  greedy_path_walker #(.MAX_STEPS(36)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .start_state(start_state),
    .target_state(target_state),
    .q_table(q_table),
    .busy(busy),
    .path_valid(path_valid),
    .path_state(path_state),
    .path_idx(path_idx),
    .done(done),
    .success(success),
    .err_code(err_code),
    .path_len(path_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] st;
    logic [5:0] idx;
  } pe_t;

  typedef struct {
    logic       succ;
    logic [2:0] err;
    logic [5:0] len;
    int         lat;
  } de_t;

  pe_t pq[$];
  de_t dq[$];
  pe_t pe;
  de_t de;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents output.
  always @(negedge clk) begin
    if (rst) begin
      if (path_valid) begin
        if (pq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_path: got state %0d idx %0d, none expected",
                   path_state, path_idx);
        end else begin
          pe = pq.pop_front();
          chk("path_state", 32'(path_state), 32'(pe.st));
          chk("path_idx", 32'(path_idx), 32'(pe.idx));
        end
      end
      if (done) begin
        done_cnt++;
        if (dq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got err %0d, no done expected",
                   err_code);
        end else begin
          de = dq.pop_front();
          chk("success", 32'(success), 32'(de.succ));
          chk("err_code", 32'(err_code), 32'(de.err));
          chk("path_len", 32'(path_len), 32'(de.len));
          chk("done_latency", 32'(cyc - start_cyc + 1), 32'(de.lat));
        end
      end
    end
  end

  task automatic clear_q();
    for (int s = 0; s < 37; s++)
      for (int a = 0; a < 4; a++)
        q_table[s][a] = 32'd0;
  endtask

  task automatic exp_path(input logic [5:0] st, input logic [5:0] idx);
    pe_t e;
    e.st = st;
    e.idx = idx;
    pq.push_back(e);
  endtask

  task automatic exp_done(input logic s, input logic [2:0] e,
                          input logic [5:0] l, input int lat);
    de_t d;
    d.succ = s;
    d.err = e;
    d.len = l;
    d.lat = lat;
    dq.push_back(d);
  endtask

  task automatic issue(input logic [5:0] ss, input logic [5:0] ts);
    @(negedge clk);
    start_state = ss;
    target_state = ts;
    start = 1'b1;
    @(posedge clk);
    #1 start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string nm);
    int n = 0;
    while (done_cnt == d0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == d0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no done, expected done within 300 cycles",
               nm);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input logic [5:0] ss, input logic [5:0] ts,
                     input bit poke, input string nm);
    int d0 = done_cnt;
    issue(ss, ts);
    if (poke) begin
      repeat (4) @(negedge clk);
      start_state = 6'd30;
      target_state = 6'd31;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(d0, nm);
  endtask

  task automatic straight_setup();
    clear_q();
    for (int s = 1; s <= 5; s++) q_table[s][1] = 32'd10;
    for (int s = 1; s <= 6; s++) exp_path(6'(s), 6'(s - 1));
    exp_done(1'b1, 3'd0, 6'd5, 32);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_path_valid"}, 32'(path_valid), 32'd0);
    chk({tag, "_path_state"}, 32'(path_state), 32'd0);
    chk({tag, "_path_idx"}, 32'(path_idx), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_success"}, 32'(success), 32'd0);
    chk({tag, "_err_code"}, 32'(err_code), 32'd0);
    chk({tag, "_path_len"}, 32'(path_len), 32'd0);
  endtask

  initial begin
    clear_q();
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Straight east walk, with a start poke that must be ignored.
    straight_setup();
    run(6'd1, 6'd6, 1'b1, "straight");
    repeat (3) @(negedge clk);
    chk("hold_success", 32'(success), 32'd1);
    chk("hold_err", 32'(err_code), 32'd0);
    chk("hold_len", 32'(path_len), 32'd5);

    // Dead end: no nonzero Q anywhere.
    clear_q();
    exp_path(6'd1, 6'd0);
    exp_done(1'b0, 3'd1, 6'd0, 7);
    run(6'd1, 6'd36, 1'b0, "dead_end");

    // Loop: 1 -> 2 -> back to 1.
    clear_q();
    q_table[1][1] = 32'd5;
    q_table[2][3] = 32'd5;
    exp_path(6'd1, 6'd0);
    exp_path(6'd2, 6'd1);
    exp_done(1'b0, 3'd2, 6'd1, 13);
    run(6'd1, 6'd36, 1'b0, "loop");

    // Tie between N and E keeps N.
    clear_q();
    q_table[8][0] = 32'd7;
    q_table[8][1] = 32'd7;
    exp_path(6'd8, 6'd0);
    exp_path(6'd2, 6'd1);
    exp_done(1'b1, 3'd0, 6'd1, 8);
    run(6'd8, 6'd2, 1'b0, "tie");

    // East is illegal from the last column.
    clear_q();
    q_table[6][1] = 32'hFFFF_FFFF;
    q_table[6][2] = 32'd1;
    exp_path(6'd6, 6'd0);
    exp_path(6'd12, 6'd1);
    exp_done(1'b1, 3'd0, 6'd1, 8);
    run(6'd6, 6'd12, 1'b0, "edge");

    // Start equals target.
    clear_q();
    exp_path(6'd15, 6'd0);
    exp_done(1'b1, 3'd0, 6'd0, 2);
    run(6'd15, 6'd15, 1'b0, "same");

    // Bad inputs: no path entries at all.
    exp_done(1'b0, 3'd4, 6'd0, 1);
    run(6'd0, 6'd5, 1'b0, "bad_start");
    exp_done(1'b0, 3'd4, 6'd0, 1);
    run(6'd3, 6'd40, 1'b0, "bad_target");

    // Reset during EVAL of the second move.
    clear_q();
    for (int s = 1; s <= 5; s++) q_table[s][1] = 32'd10;
    exp_path(6'd1, 6'd0);
    exp_path(6'd2, 6'd1);
    issue(6'd1, 6'd6);
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero("midreset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Rerun of the straight walk after reset.
    straight_setup();
    run(6'd1, 6'd6, 1'b0, "rerun");

    chk("path_queue_empty", 32'(pq.size()), 32'd0);
    chk("done_queue_empty", 32'(dq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
